// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 3-bit-ALUOp ALU: decodes one instruction per handshake and drives the ALU from it.
// It registers the ALU result and hands it off. Defining ALU_ISSUE_BYPASS_EN forwards the last handed-off result into the operands.
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic [REG_AW-1:0] rs_addr,
    output logic [REG_AW-1:0] rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] alu_imm,
    output logic [2:0]        alu_op,
    output logic              alu_srcb,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wen,
    output logic              out_taken,
    output logic              out_illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_ANDI = 6'b010011;
    localparam logic [5:0] OP_XOR  = 6'b010100;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_BNE  = 6'b110001;

    state_t      state;
    state_t      state_next;
    logic [31:0] instr_q;
    logic        accept;
    logic        handoff;

    logic [5:0]  op;
    logic [15:0] imm;
    logic        dec_zext;
    logic        dec_rtype;
    logic        dec_wen;
    logic        dec_beq;
    logic        dec_bne;
    logic        dec_illegal;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = EXEC;
            EXEC:    state_next = HOLD;
            HOLD:    if (out_ready) state_next = in_valid ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    assign accept  = in_valid & in_ready;
    assign handoff = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       instr_q <= '0;
        else if (accept) instr_q <= instr;
    end

    assign op      = instr_q[31:26];
    assign imm     = instr_q[15:0];
    assign rs_addr = instr_q[25:21];
    assign rt_addr = instr_q[20:16];

    always_comb begin
        alu_op      = 3'b000;
        alu_srcb    = 1'b0;
        dec_zext    = 1'b0;
        dec_rtype   = 1'b0;
        dec_wen     = 1'b0;
        dec_beq     = 1'b0;
        dec_bne     = 1'b0;
        dec_illegal = 1'b0;
        case (op)
            OP_ADD:  begin alu_op = 3'b000; dec_rtype = 1'b1; dec_wen = 1'b1; end
            OP_SUB:  begin alu_op = 3'b001; dec_rtype = 1'b1; dec_wen = 1'b1; end
            OP_ADDI: begin alu_op = 3'b000; alu_srcb = 1'b1; dec_wen = 1'b1; end
            OP_OR:   begin alu_op = 3'b011; dec_rtype = 1'b1; dec_wen = 1'b1; end
            OP_AND:  begin alu_op = 3'b100; dec_rtype = 1'b1; dec_wen = 1'b1; end
            OP_ORI:  begin alu_op = 3'b011; alu_srcb = 1'b1; dec_zext = 1'b1; dec_wen = 1'b1; end
            OP_ANDI: begin alu_op = 3'b100; alu_srcb = 1'b1; dec_zext = 1'b1; dec_wen = 1'b1; end
            OP_XOR:  begin alu_op = 3'b110; dec_rtype = 1'b1; dec_wen = 1'b1; end
            OP_BEQ:  begin alu_op = 3'b001; dec_beq = 1'b1; end
            OP_BNE:  begin alu_op = 3'b001; dec_bne = 1'b1; end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Unlisted opcodes fall back to sign extension.
    assign alu_imm = dec_zext ? {{(DATA_W-16){1'b0}}, imm} : {{(DATA_W-16){imm[15]}}, imm};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_result  <= '0;
            out_rd      <= '0;
            out_wen     <= 1'b0;
            out_taken   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (state == EXEC) begin
            out_result  <= alu_result;
            out_rd      <= dec_rtype ? instr_q[15:11] : instr_q[20:16];
            out_wen     <= dec_wen;
            out_taken   <= (dec_beq & alu_zero) | (dec_bne & ~alu_zero);
            out_illegal <= dec_illegal;
        end
    end

`ifdef ALU_ISSUE_BYPASS_EN
    logic [DATA_W-1:0] kept_result;
    logic [REG_AW-1:0] kept_rd;
    logic              kept_wen;
    logic              hit_a;
    logic              hit_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kept_result <= '0;
            kept_rd     <= '0;
            kept_wen    <= 1'b0;
        end else if (handoff) begin
            kept_result <= out_result;
            kept_rd     <= out_rd;
            kept_wen    <= out_wen;
        end
    end

    // Register 0 is never forwarded, since writes to it are discarded downstream.
    assign hit_a = (state == EXEC) && kept_wen && (kept_rd != '0) && (kept_rd == rs_addr);
    assign hit_b = (state == EXEC) && kept_wen && (kept_rd != '0) && (kept_rd == rt_addr);
    assign alu_a = hit_a ? kept_result : rs_data;
    assign alu_b = hit_b ? kept_result : rt_data;
`else
    assign alu_a = rs_data;
    assign alu_b = rt_data;
`endif

endmodule
